mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage load/store engine. Consumes the EX/MEM pipeline register outputs (control bits, funct3, ALU address, rs2 data) and drives a req/ack data-memory port.
- Produces byte-enabled, lane-shifted stores and sign/zero-extended load data for MEM/WB.
- Raises stall_out so the upstream pipeline registers hold while a multi-cycle access is in flight.

Parameters:
- XLEN, 32, datapath/address width; only 32 is supported.
- TIMEOUT, 64, maximum cycles in ACCESS without dmem_ack before a bus error; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- res  in  1  asynchronous active-low reset
- mem_read_in  in  1  load request (from EX/MEM)
- mem_write_in  in  1  store request (from EX/MEM)
- funct3_in  in  3  access size/sign (RV32I encoding)
- addr_in  in  32  byte address (ALU result)
- wdata_in  in  32  store data (rs2)
- stall_out  out  1  1 = hold IF/ID, ID/EX and EX/MEM
- dmem_req  out  1  memory request, level-held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_ack  in  1  access complete; rdata valid in the same cycle
- dmem_rdata  in  32  read word
- load_data_out  out  32  formatted load result
- load_valid_out  out  1  one-cycle pulse with load_data_out
- bus_err_out  out  1  one-cycle pulse on timeout
- misaligned_out  out  1  one-cycle pulse on misaligned access (tied 0 without the feature)

Behaviour:
- Reset (res=0, asynchronous): state=IDLE; counter=0; every output 0; dmem_req drops immediately, including mid-access. An outstanding ack after reset release is ignored.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - access = mem_read_in | mem_write_in; if both are set, write wins.
  - stall_out = access (combinational).
  - On access: register addr, be, wdata, we, funct3; go to ACCESS; counter=0.
- ACCESS:
  - dmem_req=1; stall_out=1; address/be/data held stable.
  - On dmem_ack: register the formatted rdata (loads only) and go to RESP.
  - Otherwise counter++. When counter==TIMEOUT-1 and TIMEOUT!=0: drop req, go to RESP with error flag.
- RESP:
  - stall_out=0, so EX/MEM advances at this edge.
  - load_valid_out=1 for a completed load; bus_err_out=1 on error, with load_data_out=0.
  - Unconditionally return to IDLE. RESP never re-triggers, because EX/MEM still shows the same instruction during RESP.
- Latency: ack in the first ACCESS cycle gives 3 cycles per access (IDLE, ACCESS, RESP); each extra wait cycle adds 1.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW: be=1111.
  - funct3 011/11x on a store: treated as SW.
- Load formatting uses the registered addr[1:0]:
  - LB/LBU select the byte and sign/zero-extend.
  - LH/LHU select the half by addr[1].
  - LW passes the word through.
  - 011/110/111 on a load: treated as LW.
- load_data_out holds its value until the next load completes; it is not cleared at RESP exit except on error.
- Loads drive dmem_be=1111.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - A misaligned access skips ACCESS (no dmem_req) and goes IDLE->RESP, so stall_out is high for 1 cycle.
  - RESP pulses misaligned_out=1; load_valid_out=0.
- Undefined:
  - Low address bits beyond the access size are ignored (forced alignment) and the access proceeds normally.
  - misaligned_out is tied to 0.

Decomposition:
- Package mem_pkg:
  - funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
  - State encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
- One natural sub-module: load_align, purely combinational (rdata, funct3, addr[1:0] -> formatted 32-bit result). It is instantiated once and reused by the bench as a reference model.

Test Plan:
1. SW addr=0x100 data=0xDEADBEEF, ack in the first ACCESS cycle -> dmem_we=1, be=1111, dmem_addr=0x100; stall_out high for exactly 2 cycles; no load_valid_out.
2. LB addr=0x203, rdata=0x80FF_1234 -> be=1111, load_data_out=0xFFFFFF80; LBU at the same address -> 0x00000080; load_valid_out pulses once per load.
3. SH addr=0x102 data=0x0000ABCD, ack after 4 wait cycles -> be=1100, wdata=0xABCDABCD; req held stable 5 cycles; stall_out high 6 cycles.
4. LW with dmem_ack never asserted, TIMEOUT=64 -> req drops after 64 ACCESS cycles; bus_err_out pulses 1; load_data_out=0; FSM back in IDLE.
5. res pulled low during the 3rd ACCESS cycle -> dmem_req and stall_out are 0 asynchronously; after release, an ack produces no load_valid_out.
6. MISALIGN_TRAP_EN defined, LW addr=0x101 -> no dmem_req, stall_out 1 cycle, misaligned_out pulse. Undefined: the same access issues to 0x100 and returns the word.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store engine:
// funct3 codes, FSM states, byte-enable patterns and store-lane helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Unlisted store encodings fall through to a full-word write.
    function automatic logic [3:0] store_be(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        case (f3)
            F3_B:    store_be = BE_BYTE << off;
            F3_H:    store_be = BE_HALF << {off[1], 1'b0};
            default: store_be = BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_data(
        input logic [2:0]  f3,
        input logic [31:0] rs2
    );
        case (f3)
            F3_B:    store_data = {4{rs2[7:0]}};
            F3_H:    store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/half
// from the read word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[8*addr_lo +: 8];
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{b[7]}}, b};
            F3_BU:   result = {24'd0, b};
            F3_H:    result = {{16{h[15]}}, h};
            F3_HU:   result = {16'd0, h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine with a req/ack data port and timeout.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            res,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] wdata_in,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] load_data_out,
    output logic            load_valid_out,
    output logic            bus_err_out,
    output logic            misaligned_out
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   ldata_q;
    logic [3:0]        be_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic              err_q;
    logic              mis_q;
    logic              access;
    logic              mis;
    logic              to_hit;
    logic              stall_c;
    logic [XLEN-1:0]   fmt;

    assign access = mem_read_in | mem_write_in;
    assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

`ifdef MISALIGN_TRAP_EN
    logic is_b;
    logic is_h;

    // Load BU/HU share the byte/half sizing; stores only know B and H.
    always_comb begin
        is_b = (funct3_in == F3_B)
             | (!mem_write_in && funct3_in == F3_BU);
        is_h = (funct3_in == F3_H)
             | (!mem_write_in && funct3_in == F3_HU);
        if (is_b)
            mis = 1'b0;
        else if (is_h)
            mis = addr_in[0];
        else
            mis = |addr_in[1:0];
    end

    assign misaligned_out = (state == RESP) && mis_q;
`else
    assign mis            = 1'b0;
    assign misaligned_out = 1'b0;
`endif

    load_align u_align (
        .rdata   (dmem_rdata),
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .result  (fmt)
    );

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        unique case (state)
            IDLE: begin
                stall_c = access;
                if (access)
                    state_nx = mis ? RESP : ACCESS;
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (dmem_ack || to_hit)
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Gate with reset so the pipeline is released while res is low.
    assign stall_out = res & stall_c;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (access) begin
                        addr_q  <= addr_in;
                        we_q    <= mem_write_in;
                        f3_q    <= funct3_in;
                        be_q    <= mem_write_in
                                 ? store_be(funct3_in, addr_in[1:0])
                                 : BE_WORD;
                        wdata_q <= store_data(funct3_in, wdata_in);
                        cnt     <= '0;
                        err_q   <= 1'b0;
                        mis_q   <= mis;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        if (!we_q)
                            ldata_q <= fmt;
                    end else if (to_hit) begin
                        err_q   <= 1'b1;
                        ldata_q <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req       = (state == ACCESS);
    assign dmem_we        = we_q;
    assign dmem_addr      = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;
    assign load_data_out  = ldata_q;
    assign load_valid_out = (state == RESP) & ~we_q & ~err_q & ~mis_q;
    assign bus_err_out    = (state == RESP) & err_q;

endmodule
